// File: rtl/thor2022_io_bridge.sv
// Splits 128-bit Wishbone accesses into per-lane 32-bit peripheral cycles and merges the result.
// Optional macro THOR2022_IOBRIDGE_TIMEOUT_EN adds a per-lane bus timeout that completes with an error.
module thor2022_io_bridge #(
    parameter int unsigned TMO_BITS  = 10,
    parameter logic [31:0] RESET_DAT = 32'h0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_cyc_i,
    input  logic         s_stb_i,
    input  logic         s_we_i,
    input  logic [15:0]  s_sel_i,
    input  logic [31:0]  s_adr_i,
    input  logic [127:0] s_dat_i,
    output logic         s_ack_o,
    output logic         s_err_o,
    output logic [127:0] s_dat_o,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [3:0]   m_sel_o,
    output logic [31:0]  m_adr_o,
    output logic [31:0]  m_dat_o,
    input  logic         m_ack_i,
    input  logic         m_err_i,
    input  logic [31:0]  m_dat_i
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned SEL_W  = 16;
    localparam int unsigned BUS_W  = LANES * LANE_W;

    typedef enum logic [2:0] {IDLE, SCAN, XFER, DONE, WAITEND} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [27:0]        adr_q, adr_d;
    logic [BUS_W-1:0]   wdat_q, wdat_d;
    logic [BUS_W-1:0]   rdat_q, rdat_d;
    logic [2:0]         idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic               err_q, err_d;
    logic               s_ack_q, s_ack_d;
    logic               s_err_q, s_err_d;
    logic               m_cyc_q, m_cyc_d;
    logic               m_stb_q, m_stb_d;
    logic               m_we_q, m_we_d;
    logic [3:0]         m_sel_q, m_sel_d;
    logic [31:0]        m_adr_q, m_adr_d;
    logic [LANE_W-1:0]  m_dat_q, m_dat_d;
    logic               scan_hit_c;
    logic [1:0]         scan_lane_c;
    logic               tmo_hit_c;
    logic               unused_c;

    assign unused_c = ^{s_adr_i[3:0], 1'(TMO_BITS)};

`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
    // Fires in the (2**TMO_BITS-1)th silent XFER cycle.
    localparam logic [TMO_BITS-1:0] TMO_LAST = ~TMO_BITS'(1);
    logic [TMO_BITS-1:0] tmo_q, tmo_d;
    assign tmo_hit_c = (tmo_q == TMO_LAST);
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Lowest lane at or above the index with any byte select set.
    always_comb begin
        scan_hit_c  = 1'b0;
        scan_lane_c = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (3'(i) >= idx_q && sel_q[4*i +: 4] != 4'h0) begin
                scan_hit_c  = 1'b1;
                scan_lane_c = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        err_d   = err_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_we_d  = m_we_q;
        m_sel_d = m_sel_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    we_d    = s_we_i;
                    sel_d   = s_sel_i;
                    adr_d   = s_adr_i[31:4];
                    wdat_d  = s_dat_i;
                    rdat_d  = {LANES{RESET_DAT}};
                    idx_d   = 3'd0;
                    err_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit_c) begin
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    m_we_d  = we_q;
                    m_sel_d = sel_q[{scan_lane_c, 2'b00} +: 4];
                    m_adr_d = {adr_q, scan_lane_c, 2'b00};
                    m_dat_d = wdat_q[{scan_lane_c, 5'b00000} +: LANE_W];
                    lane_d  = scan_lane_c;
`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = XFER;
                end else begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    state_d = DONE;
                end
            end
            XFER: begin
                if (m_err_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (m_ack_i) begin
                    if (!we_q) begin
                        rdat_d[{lane_q, 5'b00000} +: LANE_W] = m_dat_i;
                    end
                    m_stb_d = 1'b0;
                    idx_d   = {1'b0, lane_q} + 3'd1;
                    state_d = SCAN;
                end else if (tmo_hit_c) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
                    tmo_d   = tmo_q + TMO_BITS'(1);
`endif
                end
            end
            DONE: begin
                m_cyc_d = 1'b0;
                m_stb_d = 1'b0;
                s_ack_d = !err_q;
                s_err_d = err_q;
                state_d = WAITEND;
            end
            WAITEND: begin
                // A strobe still held from the finished access must not start another.
                if (!s_stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_sel_q <= m_sel_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
`ifdef THOR2022_IOBRIDGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = rdat_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

endmodule
